iic_cfg_seq: RTL and testbench

IIC_CFG_SEQ -- requirements
Module: iic_cfg_seq

---
 rtl/iic_cfg_seq.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_iic_cfg_seq.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_cfg_seq.sv
// Table-driven I2C register configuration sequencer: walks a config ROM and issues
// write / write-verify / delay commands to a byte-level I2C master, with retries and abort.
module iic_cfg_seq #(
    parameter int  DEPTH     = 64,
    parameter int  RA_BYTES  = 2,
    parameter int  DW        = 8,
    parameter int  MAX_RETRY = 3,
    parameter int  TICK_DIV  = 100000,
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int RAW       = 8 * RA_BYTES,
    localparam int EW        = 2 + 7 + RAW + DW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_start,
    input  logic           cfg_abort,
    output logic [AW-1:0]  tbl_addr,
    input  logic [EW-1:0]  tbl_data,
    output logic           cmd_valid,
    input  logic           cmd_ready,
    output logic           cmd_rd,
    output logic [6:0]     cmd_dev,
    output logic [RAW-1:0] cmd_reg,
    output logic [DW-1:0]  cmd_wdata,
    input  logic           rsp_valid,
    input  logic           rsp_nack,
    input  logic [DW-1:0]  rsp_rdata,
    output logic           busy,
    output logic           done,
    output logic           error,
    output logic [AW-1:0]  err_index,
    output logic [1:0]     err_code
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [1:0] OP_WR    = 2'd0;
    localparam logic [1:0] OP_WRVFY = 2'd1;
    localparam logic [1:0] OP_DELAY = 2'd2;

    localparam logic [1:0] ERR_NACK   = 2'd1;
    localparam logic [1:0] ERR_VERIFY = 2'd2;
    localparam logic [1:0] ERR_ABORT  = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_WR_REQ,
        S_WR_RSP,
        S_RD_REQ,
        S_RD_RSP,
        S_DELAY,
        S_NEXT,
        S_FIN,
        S_FAIL
    } state_t;

    state_t          state;
    logic            start_q1;
    logic            start_q2;
    logic            start_edge;
    logic [AW-1:0]   index;
    logic [RW-1:0]   retry;
    logic            retry_ok;
    logic [1:0]      op;
    logic [DW-1:0]   ent_data;
    logic            abort_pend;
    logic [PW-1:0]   presc;
    logic [DW-1:0]   ticks;

    logic [1:0]      f_op;
    logic [6:0]      f_dev;
    logic [RAW-1:0]  f_reg;
    logic [DW-1:0]   f_data;

    assign f_op       = tbl_data[EW-1 -: 2];
    assign f_dev      = tbl_data[EW-3 -: 7];
    assign f_reg      = tbl_data[DW+RAW-1 -: RAW];
    assign f_data     = tbl_data[DW-1:0];
    assign start_edge = start_q1 & ~start_q2;
    assign retry_ok   = (retry < RW'(MAX_RETRY));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            start_q1   <= 1'b0;
            start_q2   <= 1'b0;
            index      <= '0;
            retry      <= '0;
            op         <= '0;
            ent_data   <= '0;
            abort_pend <= 1'b0;
            presc      <= '0;
            ticks      <= '0;
            tbl_addr   <= '0;
            cmd_valid  <= 1'b0;
            cmd_rd     <= 1'b0;
            cmd_dev    <= '0;
            cmd_reg    <= '0;
            cmd_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_index  <= '0;
            err_code   <= '0;
        end else begin
            start_q1 <= cfg_start;
            start_q2 <= start_q1;

            case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        done       <= 1'b0;
                        error      <= 1'b0;
                        err_code   <= '0;
                        err_index  <= '0;
                        index      <= '0;
                        retry      <= '0;
                        abort_pend <= 1'b0;
                        busy       <= 1'b1;
                        tbl_addr   <= '0;
                        state      <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    if (cfg_abort) begin
                        err_code  <= ERR_ABORT;
                        err_index <= index;
                        state     <= S_FAIL;
                    end else begin
                        state <= S_LATCH;
                    end
                end

                S_LATCH: begin
                    if (cfg_abort) begin
                        err_code  <= ERR_ABORT;
                        err_index <= index;
                        state     <= S_FAIL;
                    end else begin
                        op        <= f_op;
                        ent_data  <= f_data;
                        cmd_dev   <= f_dev;
                        cmd_reg   <= f_reg;
                        cmd_wdata <= f_data;
                        presc     <= '0;
                        ticks     <= '0;
                        if (f_op == OP_WR || f_op == OP_WRVFY) begin
                            cmd_valid <= 1'b1;
                            cmd_rd    <= 1'b0;
                            state     <= S_WR_REQ;
                        end else if (f_op == OP_DELAY) begin
                            state <= S_DELAY;
                        end else begin
                            state <= S_FIN;
                        end
                    end
                end

                // An accepted command always gets its response awaited, even under abort.
                S_WR_REQ, S_RD_REQ: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= (state == S_WR_REQ) ? S_WR_RSP : S_RD_RSP;
                        if (cfg_abort) abort_pend <= 1'b1;
                    end else if (cfg_abort) begin
                        cmd_valid <= 1'b0;
                        err_code  <= ERR_ABORT;
                        err_index <= index;
                        state     <= S_FAIL;
                    end
                end

                S_WR_RSP: begin
                    if (rsp_valid) begin
                        if (abort_pend || cfg_abort) begin
                            err_code  <= ERR_ABORT;
                            err_index <= index;
                            state     <= S_FAIL;
                        end else if (rsp_nack) begin
                            if (retry_ok) begin
                                retry     <= retry + 1'b1;
                                cmd_valid <= 1'b1;
                                cmd_rd    <= 1'b0;
                                state     <= S_WR_REQ;
                            end else begin
                                err_code  <= ERR_NACK;
                                err_index <= index;
                                state     <= S_FAIL;
                            end
                        end else if (op == OP_WRVFY) begin
                            cmd_valid <= 1'b1;
                            cmd_rd    <= 1'b1;
                            state     <= S_RD_REQ;
                        end else begin
                            state <= S_NEXT;
                        end
                    end else if (cfg_abort) begin
                        abort_pend <= 1'b1;
                    end
                end

                // A failed verify retries the whole write+read pair.
                S_RD_RSP: begin
                    if (rsp_valid) begin
                        if (abort_pend || cfg_abort) begin
                            err_code  <= ERR_ABORT;
                            err_index <= index;
                            state     <= S_FAIL;
                        end else if (rsp_nack || rsp_rdata != ent_data) begin
                            if (retry_ok) begin
                                retry     <= retry + 1'b1;
                                cmd_valid <= 1'b1;
                                cmd_rd    <= 1'b0;
                                state     <= S_WR_REQ;
                            end else begin
                                err_code  <= rsp_nack ? ERR_NACK : ERR_VERIFY;
                                err_index <= index;
                                state     <= S_FAIL;
                            end
                        end else begin
                            state <= S_NEXT;
                        end
                    end else if (cfg_abort) begin
                        abort_pend <= 1'b1;
                    end
                end

                S_DELAY: begin
                    if (cfg_abort) begin
                        err_code  <= ERR_ABORT;
                        err_index <= index;
                        state     <= S_FAIL;
                    end else if (ticks == ent_data) begin
                        state <= S_NEXT;
                    end else if (presc == PW'(TICK_DIV - 1)) begin
                        presc <= '0;
                        ticks <= ticks + 1'b1;
                        if (ticks + DW'(1) == ent_data) state <= S_NEXT;
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end

                S_NEXT: begin
                    if (cfg_abort) begin
                        err_code  <= ERR_ABORT;
                        err_index <= index;
                        state     <= S_FAIL;
                    end else begin
                        retry <= '0;
                        if (index == AW'(DEPTH - 1)) begin
                            state <= S_FIN;
                        end else begin
                            index    <= index + 1'b1;
                            tbl_addr <= index + 1'b1;
                            state    <= S_FETCH;
                        end
                    end
                end

                S_FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                S_FAIL: begin
                    error      <= 1'b1;
                    busy       <= 1'b0;
                    abort_pend <= 1'b0;
                    state      <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iic_cfg_seq.sv
// Directed bench for iic_cfg_seq: a registered ROM model, a scripted I2C slave and a
// command scoreboard, with a linear sequence of test steps.
module tb_iic_cfg_seq;

    localparam int EW = 33;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_start;
    logic          cfg_abort;
    logic [1:0]    tbl_addr;
    logic [EW-1:0] tbl_data;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_rd;
    logic [6:0]    cmd_dev;
    logic [15:0]   cmd_reg;
    logic [7:0]    cmd_wdata;
    logic          rsp_valid;
    logic          rsp_nack;
    logic [7:0]    rsp_rdata;
    logic          busy;
    logic          done;
    logic          error;
    logic [1:0]    err_index;
    logic [1:0]    err_code;

    int tests = 0;
    int fails = 0;

    logic [EW-1:0] rom [4];
    logic [1:0]    addr_q = '0;
    logic [31:0]   exp_q[$];
    logic [31:0]   act_q[$];
    logic          nack_q[$];
    logic [7:0]    corrupt = '0;
    int            rsp_lat = 2;

    iic_cfg_seq #(
        .DEPTH(4), .RA_BYTES(2), .DW(8), .MAX_RETRY(3), .TICK_DIV(10)
    ) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
        .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .rsp_rdata(rsp_rdata),
        .busy(busy), .done(done), .error(error),
        .err_index(err_index), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // ROM with one cycle of address-to-data latency
    initial begin
        tbl_data = '0;
        forever begin
            @(negedge clk);
            tbl_data = rom[addr_q];
            addr_q   = tbl_addr;
        end
    end

    // Slave: logs each accepted command and answers rsp_lat cycles later
    initial begin
        int dly = 0;
        logic pend_nack = 1'b0;
        logic [7:0] mem_wd = '0;
        logic [7:0] pend_rdata = '0;
        rsp_valid = 1'b0;
        rsp_nack  = 1'b0;
        rsp_rdata = '0;
        forever begin
            @(negedge clk);
            rsp_valid = 1'b0;
            rsp_nack  = 1'b0;
            if (rst) begin
                dly = 0;
            end else begin
                if (dly == 1) begin
                    rsp_valid = 1'b1;
                    rsp_nack  = pend_nack;
                    rsp_rdata = pend_rdata;
                end
                if (dly > 0) dly--;
                if (cmd_valid && cmd_ready) begin
                    act_q.push_back({cmd_rd, cmd_dev, cmd_reg, cmd_rd ? 8'h00 : cmd_wdata});
                    if (nack_q.size() > 0) pend_nack = nack_q.pop_front();
                    else pend_nack = 1'b0;
                    if (!cmd_rd && !pend_nack) mem_wd = cmd_wdata;
                    pend_rdata = mem_wd ^ corrupt;
                    dly = rsp_lat;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [EW-1:0] mk(input logic [1:0] op, input logic [6:0] dev,
                                         input logic [15:0] rg, input logic [7:0] d);
        return {op, dev, rg, d};
    endfunction

    task automatic exp_w(input logic [6:0] dev, input logic [15:0] rg, input logic [7:0] d);
        exp_q.push_back({1'b0, dev, rg, d});
    endtask

    task automatic exp_r(input logic [6:0] dev, input logic [15:0] rg);
        exp_q.push_back({1'b1, dev, rg, 8'h00});
    endtask

    task automatic check_cmds(input string tag);
        chk({tag, " ncmd"}, act_q.size(), exp_q.size());
        while (exp_q.size() > 0 && act_q.size() > 0)
            chk({tag, " cmd"}, act_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        act_q.delete();
    endtask

    task automatic run_start(input string tag);
        int n = 0;
        cfg_start = 1'b1;
        while (!busy && n < 20) begin @(negedge clk); n++; end
        chk({tag, " start"}, busy, 1'b1);
        cfg_start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin @(negedge clk); n++; end
        chk({tag, " end in time"}, n < budget, 1'b1);
    endtask

    task automatic wait_cmds(input string tag, input int cnt);
        int n = 0;
        while (act_q.size() < cnt && n < 300) begin @(negedge clk); n++; end
        chk({tag, " cmd seen"}, n < 300, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        cfg_start = 1'b1;
        cfg_abort = 1'b0;
        cmd_ready = 1'b1;
        rom[0] = mk(2'd0, 7'h3C, 16'h3008, 8'h82);
        rom[1] = mk(2'd3, 7'h00, 16'h0000, 8'h00);
        rom[2] = mk(2'd3, 7'h00, 16'h0000, 8'h00);
        rom[3] = mk(2'd3, 7'h00, 16'h0000, 8'h00);
        repeat (3) @(negedge clk);
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst error", error, 1'b0);
        chk("rst cmd_valid", cmd_valid, 1'b0);
        chk("rst tbl_addr", tbl_addr, 2'd0);
        chk("rst err_code", err_code, 2'd0);
        chk("rst err_index", err_index, 2'd0);

        // Single write; start held high through reset launches the run
        exp_w(7'h3C, 16'h3008, 8'h82);
        rst = 1'b0;
        run_start("t1");
        wait_end("t1", 200);
        chk("t1 done", done, 1'b1);
        chk("t1 error", error, 1'b0);
        chk("t1 err_code", err_code, 2'd0);
        check_cmds("t1");
        repeat (3) @(negedge clk);

        // Verify entry whose readback is always off by one bit
        rom[0] = mk(2'd1, 7'h3C, 16'h0010, 8'h55);
        corrupt = 8'h01;
        for (int i = 0; i < 4; i++) begin
            exp_w(7'h3C, 16'h0010, 8'h55);
            exp_r(7'h3C, 16'h0010);
        end
        run_start("t2");
        wait_end("t2", 500);
        chk("t2 error", error, 1'b1);
        chk("t2 done", done, 1'b0);
        chk("t2 err_code", err_code, 2'd2);
        chk("t2 err_index", err_index, 2'd0);
        check_cmds("t2");
        corrupt = 8'h00;
        repeat (3) @(negedge clk);

        // Two NACKs then ACK, then the next entry
        rom[0] = mk(2'd0, 7'h20, 16'h0001, 8'h11);
        rom[1] = mk(2'd0, 7'h21, 16'h0002, 8'h22);
        nack_q.push_back(1'b1);
        nack_q.push_back(1'b1);
        repeat (3) exp_w(7'h20, 16'h0001, 8'h11);
        exp_w(7'h21, 16'h0002, 8'h22);
        run_start("t3");
        wait_end("t3", 500);
        chk("t3 done", done, 1'b1);
        chk("t3 error", error, 1'b0);
        check_cmds("t3");
        repeat (3) @(negedge clk);

        // Delay of 5 ticks (TICK_DIV=10), then a zero delay, then a write
        rom[0] = mk(2'd2, 7'h00, 16'h0000, 8'd5);
        rom[1] = mk(2'd2, 7'h00, 16'h0000, 8'd0);
        rom[2] = mk(2'd0, 7'h40, 16'h1234, 8'hA5);
        rom[3] = mk(2'd3, 7'h00, 16'h0000, 8'h00);
        exp_w(7'h40, 16'h1234, 8'hA5);
        run_start("t4");
        n = 0;
        while (tbl_addr != 2'd1 && n < 200) begin @(negedge clk); n++; end
        // busy rises on entering FETCH; DELAY is entered two cycles later
        chk("t4 delay window", (n - 2 >= 48) && (n - 2 <= 52), 1'b1);
        wait_end("t4", 200);
        chk("t4 done", done, 1'b1);
        check_cmds("t4");
        repeat (3) @(negedge clk);

        // Abort while the index-2 command is held by a stalled master
        rom[0] = mk(2'd0, 7'h10, 16'h0100, 8'h01);
        rom[1] = mk(2'd0, 7'h11, 16'h0101, 8'h02);
        rom[2] = mk(2'd0, 7'h12, 16'h0102, 8'h03);
        exp_w(7'h10, 16'h0100, 8'h01);
        exp_w(7'h11, 16'h0101, 8'h02);
        run_start("t5");
        wait_cmds("t5", 2);
        cmd_ready = 1'b0;
        n = 0;
        while (!cmd_valid && n < 200) begin @(negedge clk); n++; end
        chk("t5 valid held", cmd_valid, 1'b1);
        repeat (2) @(negedge clk);
        chk("t5 still held", cmd_valid, 1'b1);
        chk("t5 held dev", cmd_dev, 7'h12);
        cfg_abort = 1'b1;
        @(negedge clk);
        cfg_abort = 1'b0;
        chk("t5 valid drop", cmd_valid, 1'b0);
        wait_end("t5", 50);
        chk("t5 error", error, 1'b1);
        chk("t5 err_code", err_code, 2'd3);
        chk("t5 err_index", err_index, 2'd2);
        cmd_ready = 1'b1;
        check_cmds("t5");
        repeat (3) @(negedge clk);

        // Four writes, no END entry, second start edge mid-run
        rom[3] = mk(2'd0, 7'h13, 16'h0103, 8'h04);
        exp_w(7'h10, 16'h0100, 8'h01);
        exp_w(7'h11, 16'h0101, 8'h02);
        exp_w(7'h12, 16'h0102, 8'h03);
        exp_w(7'h13, 16'h0103, 8'h04);
        run_start("t6");
        wait_cmds("t6", 1);
        cfg_start = 1'b1;
        repeat (3) @(negedge clk);
        cfg_start = 1'b0;
        wait_end("t6", 300);
        chk("t6 done", done, 1'b1);
        chk("t6 error", error, 1'b0);
        repeat (10) @(negedge clk);
        chk("t6 no rerun", busy, 1'b0);
        check_cmds("t6");
        repeat (3) @(negedge clk);

        // Abort while a response is outstanding: response awaited first
        rom[1] = mk(2'd3, 7'h00, 16'h0000, 8'h00);
        rsp_lat = 6;
        exp_w(7'h10, 16'h0100, 8'h01);
        run_start("t7");
        n = 0;
        while (act_q.size() < 1 && n < 100) begin @(negedge clk); n++; end
        cfg_abort = 1'b1;
        @(negedge clk);
        cfg_abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("t7 awaiting rsp", busy, 1'b1);
        chk("t7 no new cmd", cmd_valid, 1'b0);
        wait_end("t7", 50);
        chk("t7 error", error, 1'b1);
        chk("t7 err_code", err_code, 2'd3);
        chk("t7 err_index", err_index, 2'd0);
        check_cmds("t7");
        rsp_lat = 2;
        repeat (3) @(negedge clk);

        // NACK exhaustion on entry 1
        rom[0] = mk(2'd0, 7'h30, 16'h0040, 8'h0A);
        rom[1] = mk(2'd0, 7'h31, 16'h0041, 8'h0B);
        rom[2] = mk(2'd3, 7'h00, 16'h0000, 8'h00);
        rom[3] = mk(2'd3, 7'h00, 16'h0000, 8'h00);
        nack_q.push_back(1'b0);
        repeat (4) nack_q.push_back(1'b1);
        exp_w(7'h30, 16'h0040, 8'h0A);
        repeat (4) exp_w(7'h31, 16'h0041, 8'h0B);
        run_start("t8");
        wait_end("t8", 500);
        chk("t8 error", error, 1'b1);
        chk("t8 err_code", err_code, 2'd1);
        chk("t8 err_index", err_index, 2'd1);
        check_cmds("t8");
        repeat (3) @(negedge clk);

        // Reset while a command is held drops cmd_valid at once
        cmd_ready = 1'b0;
        run_start("t9");
        n = 0;
        while (!cmd_valid && n < 50) begin @(negedge clk); n++; end
        chk("t9 valid before rst", cmd_valid, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("t9 rst valid", cmd_valid, 1'b0);
        chk("t9 rst busy", busy, 1'b0);
        rst = 1'b0;
        cmd_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("t9 stays idle", busy, 1'b0);
        act_q.delete();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
